load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of reqAddr and memAddr.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-004 SHALL have port reqValid  input  1  CPU request present.
REQ-005 SHALL have port reqReady  output  1  unit can accept a request; high exactly in IDLE.
REQ-006 SHALL have port reqWrite  input  1  1 = store, 0 = load.
REQ-007 SHALL have port reqSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port reqSigned  input  1  loads only: 1 sign-extends, 0 zero-extends.
REQ-009 SHALL have port reqAddr  input  ADDR_W  byte address.
REQ-010 SHALL have port reqWData  input  32  store data, right-justified.
REQ-011 SHALL have port respValid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port respRData  output  32  load result; valid while respValid is high.
REQ-013 SHALL have port misaligned  output  1  high with respValid when the request was rejected.
REQ-014 SHALL have port memAddr  output  ADDR_W  word-aligned address to the word memory: latched address with bits [1:0] forced to 00.
REQ-015 SHALL have port memWrEn  output  1  memory write enable; the memory writes on the rising clk edge.
REQ-016 SHALL have port memWData  output  32  word written to memory.
REQ-017 SHALL have port memRData  input  32  combinational read data for memAddr.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, RMW_READ, STORE and DONE.
REQ-019 SHALL latch reqWrite, reqSize, reqSigned, reqAddr and reqWData on an edge where reqValid and reqReady are both high; inputs are ignored at all other times.
REQ-020 SHALL take these transitions on acceptance: misaligned -> DONE; load -> LOAD; word store -> STORE; byte/half store -> RMW_READ.
REQ-021 SHALL treat as misaligned: reqSize=11; halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-022 SHALL, for a misaligned request, perform no memory access, set respRData=0 and pulse misaligned with respValid.
REQ-023 SHALL use little-endian byte lanes: byte at addr[1:0]=k occupies memRData[8k+7:8k]; the halfword at addr[1]=h occupies [16h+15:16h].
REQ-024 SHALL, in LOAD, extract the addressed lane from memRData, extend it to 32 bits per the latched reqSigned (word loads pass through unchanged), register it into respRData at the edge, then go to DONE.
REQ-025 SHALL, in RMW_READ, register memRData with only the addressed lane replaced by the low byte/half of the latched wdata, then go to STORE.
REQ-026 SHALL, in STORE, assert memWrEn=1 and drive memWData (the merged word, or wdata for a word store) for exactly one cycle, then go to DONE.
REQ-027 SHALL, in DONE, assert respValid=1 for exactly one cycle, then go to IDLE.
REQ-028 SHALL keep memWrEn=0 in every state except STORE.
REQ-029 SHALL complete requests in these cycle counts from the acceptance edge to the respValid-high cycle: load 2, word store 2, sub-word store 3, misaligned 1.
REQ-030 SHALL hold respRData from the completion of one request until the next load completes; stores leave it unchanged.
REQ-031 SHALL accept a new request in the cycle immediately after DONE, so at most one request is in flight.

Reset
REQ-032 SHALL, while rst_n=0, force state IDLE and drive reqReady=1, respValid=0, misaligned=0, respRData=0, memAddr=0, memWrEn=0 and memWData=0, independent of clk.
REQ-033 SHALL, on reset asserted mid-operation, abort the request with no response: memWrEn drops immediately, no memory write occurs, and the first request after release is served normally.

Verification
REQ-034 SHALL verify: word store to 0x10 with wdata 0xDEADBEEF -> exactly one memWrEn cycle with memAddr=0x10; a later word load from 0x10 returns 0xDEADBEEF.
REQ-035 SHALL verify: memory word 0x11223344 at 0x20, byte store 0xAA to 0x21 -> memory word becomes 0x1122AA44 and the store completes in 3 cycles.
REQ-036 SHALL verify: memory word 0x80FF7F01 at 0x30, signed byte load from 0x32 -> 0xFFFFFFFF; unsigned halfword load from 0x32 -> 0x000080FF; signed halfword load from 0x30 -> 0x00007F01.
REQ-037 SHALL verify: word load from 0x06 and halfword store to 0x05 -> misaligned=1, respRData=0, no memWrEn pulse, response one cycle after acceptance.
REQ-038 SHALL verify: rst_n driven low during STORE of a sub-word store -> memWrEn falls immediately, the memory word is unchanged, reqReady=1, and a following load succeeds.
REQ-039 SHALL verify: reqValid held high for consecutive loads -> acceptances exactly 3 cycles apart, reqReady low between them.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : load_store_unit                                                |
// | Brief   : byte/half/word load-store engine in front of a word memory,    |
// |           with sub-word stores done as read-modify-write.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqSigned,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [31:0]       reqWData,
  output logic              respValid,
  output logic [31:0]       respRData,
  output logic              misaligned,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWrEn,
  output logic [31:0]       memWData,
  input  logic [31:0]       memRData
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_READ = 3'd2,
    STORE    = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_write;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_mis;
  logic [31:0]         r_rdata;
  logic [31:0]         r_merged;

  logic                w_accept;
  logic                w_req_mis;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [31:0]         w_merged;

  assign w_accept  = reqValid && (r_state == IDLE);
  assign w_req_mis = (reqSize == 2'b11)
                  || ((reqSize == c_SZ_HALF) && reqAddr[0])
                  || ((reqSize == c_SZ_WORD) && (reqAddr[1:0] != 2'b00));

  // Lane extraction and extension for loads (little-endian lanes).
  always_comb begin
    w_byte = memRData[{r_addr[1:0], 3'b000} +: 8];
    w_half = memRData[{r_addr[1], 4'b0000} +: 16];
    w_load = memRData;
    case (r_size)
      c_SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      c_SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
      default:   w_load = memRData;
    endcase
  end

  // Sub-word store: replace only the addressed lane of the current word.
  always_comb begin
    w_merged = memRData;
    if (r_size == c_SZ_BYTE) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (reqValid) begin
          if (w_req_mis)                 w_state_nxt = DONE;
          else if (!reqWrite)            w_state_nxt = LOAD;
          else if (reqSize == c_SZ_WORD) w_state_nxt = STORE;
          else                           w_state_nxt = RMW_READ;
        end
      end
      LOAD:     w_state_nxt = DONE;
      RMW_READ: w_state_nxt = STORE;
      STORE:    w_state_nxt = DONE;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_mis    <= 1'b0;
      r_rdata  <= 32'h0;
      r_merged <= 32'h0;
    end else begin
      if (w_accept) begin
        r_write  <= reqWrite;
        r_size   <= reqSize;
        r_signed <= reqSigned;
        r_addr   <= reqAddr;
        r_wdata  <= reqWData;
        r_mis    <= w_req_mis;
        // A rejected request reports zero data; valid stores keep the old result.
        if (w_req_mis) begin
          r_rdata <= 32'h0;
        end
      end
      if (r_state == LOAD) begin
        r_rdata <= w_load;
      end
      if (r_state == RMW_READ) begin
        r_merged <= w_merged;
      end
    end
  end

  assign reqReady   = (r_state == IDLE);
  assign respValid  = (r_state == DONE);
  assign misaligned = (r_state == DONE) && r_mis;
  assign respRData  = r_rdata;
  assign memAddr    = {r_addr[ADDR_W-1:2], 2'b00};
  assign memWrEn    = (r_state == STORE) && r_write;
  assign memWData   = (r_state != STORE) ? 32'h0
                    : (r_size == c_SZ_WORD) ? r_wdata : r_merged;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_load_store_unit                                             |
// | Brief   : self-checking bench for load_store_unit with a word memory.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              reqValid = 1'b0;
  logic              reqReady;
  logic              reqWrite = 1'b0;
  logic [1:0]        reqSize = 2'b00;
  logic              reqSigned = 1'b0;
  logic [ADDR_W-1:0] reqAddr = '0;
  logic [31:0]       reqWData = 32'h0;
  logic              respValid;
  logic [31:0]       respRData;
  logic              misaligned;
  logic [ADDR_W-1:0] memAddr;
  logic              memWrEn;
  logic [31:0]       memWData;
  logic [31:0]       memRData;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr),
    .reqWData(reqWData), .respValid(respValid), .respRData(respRData),
    .misaligned(misaligned), .memAddr(memAddr), .memWrEn(memWrEn),
    .memWData(memWData), .memRData(memRData)
  );

  // Word memory environment (256 bytes); one process owns all writes.
  logic [31:0] mem [0:63];
  logic        clr = 1'b1;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h0;
  logic [31:0] pl_data = 32'h0;

  assign memRData = mem[memAddr[7:2]];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (memWrEn) begin
      mem[memAddr[7:2]] <= memWData;
    end else if (pl_en) begin
      mem[pl_addr[7:2]] <= pl_data;
    end
  end

  // Reference model: flat byte array plus the last reported load value.
  logic [7:0]  ref_b [0:255];
  logic [31:0] last_rdata;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & ~3;
    return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  task automatic model_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input int a, input logic [31:0] wd,
                           output logic [31:0] er, output logic em, output int el);
    int nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    em = (sz == 2'd3) || ((a % nb) != 0);
    if (em) begin
      er = 32'h0; el = 1; last_rdata = 32'h0;
    end else if (!wr) begin
      v = 32'h0;
      for (int k = 0; k < nb; k++) v = v | (32'(ref_b[a+k]) << (8*k));
      if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      er = v; el = 2; last_rdata = v;
    end else begin
      for (int k = 0; k < nb; k++) ref_b[a+k] = wd[8*k +: 8];
      er = last_rdata; el = (nb == 4) ? 2 : 3;
    end
  endtask

  task automatic preload(input int a, input logic [31:0] w);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = 8'(a); pl_data = w;
    @(negedge clk);
    pl_en = 1'b0;
    for (int k = 0; k < 4; k++) ref_b[(a & ~3) + k] = w[8*k +: 8];
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mis, output int lat,
                        output int wrn, output logic [31:0] waddr);
    int  n;
    logic seen;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqSigned = sg;
    reqAddr = a; reqWData = wd;
    n = 0;
    while (!reqReady && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0; wrn = 0; waddr = 32'h0; rd = 32'h0; mis = 1'b0; seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (memWrEn) begin wrn++; waddr = memAddr; end
      if (respValid) begin rd = respRData; mis = misaligned; seen = 1'b1; end
    end
    if (!seen) lat = 99;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] er;
    logic        em;
    int          el;
  } vec_t;

  vec_t vecs [10];

  task automatic run_and_check(input string tag, input logic wr, input logic [1:0] sz,
                               input logic sg, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] er, input logic em, input int el);
    logic [31:0] rd, waddr;
    logic        mis;
    int          lat, wrn, ewr;
    do_req(wr, sz, sg, a, wd, rd, mis, lat, wrn, waddr);
    ewr = (wr && !em) ? 1 : 0;
    chk({tag, "_rdata"}, rd, er);
    chk({tag, "_mis"}, 32'(mis), 32'(em));
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_wrcnt"}, wrn, ewr);
    if (ewr == 1) begin
      chk({tag, "_waddr"}, waddr, {a[31:2], 2'b00});
      chk({tag, "_memword"}, mem[a[7:2]], ref_word(int'(a[7:0])));
    end
  endtask

  initial begin
    logic [31:0] er;
    logic        em;
    int          el;
    logic [1:0]  rsz;
    logic        rwr, rsg;
    logic [31:0] ra, rwd;
    logic        rdy [12];

    for (int i = 0; i < 256; i++) ref_b[i] = 8'h0;
    last_rdata = 32'h0;

    // Reset values must appear before any clock edge.
    #3;
    chk("rst_reqReady", 32'(reqReady), 32'h1);
    chk("rst_respValid", 32'(respValid), 32'h0);
    chk("rst_misaligned", 32'(misaligned), 32'h0);
    chk("rst_respRData", respRData, 32'h0);
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_memWrEn", 32'(memWrEn), 32'h0);
    chk("rst_memWData", memWData, 32'h0);
    repeat (3) @(negedge clk);
    clr = 1'b0;
    rst_n = 1'b1;

    preload(32'h20, 32'h1122_3344);
    preload(32'h30, 32'h80FF_7F01);

    vecs[0] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 2};
    vecs[1] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
    vecs[2] = '{1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[3] = '{1'b0, 2'd0, 1'b1, 32'h32, 32'h0,         32'hFFFF_FFFF, 1'b0, 2};
    vecs[4] = '{1'b0, 2'd1, 1'b0, 32'h32, 32'h0,         32'h0000_80FF, 1'b0, 2};
    vecs[5] = '{1'b0, 2'd1, 1'b1, 32'h30, 32'h0,         32'h0000_7F01, 1'b0, 2};
    vecs[6] = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,         32'h0,         1'b1, 1};
    vecs[7] = '{1'b1, 2'd1, 1'b0, 32'h05, 32'h1234_5678, 32'h0,         1'b1, 1};
    vecs[8] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,         32'h0,         1'b1, 1};
    vecs[9] = '{1'b0, 2'd0, 1'b0, 32'h23, 32'h0,         32'h0000_0011, 1'b0, 2};

    for (int i = 0; i < 10; i++) begin
      model_req(vecs[i].wr, vecs[i].sz, vecs[i].sg, int'(vecs[i].addr[7:0]), vecs[i].wd, er, em, el);
      run_and_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].sg,
                    vecs[i].addr, vecs[i].wd, vecs[i].er, vecs[i].em, vecs[i].el);
    end
    chk("byte_store_word", mem[8], 32'h1122_AA44);

    // Reset asserted while a sub-word store sits in STORE.
    preload(32'h40, 32'h5566_7788);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0; reqAddr = 32'h41; reqWData = 32'hCC;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_wren_before", 32'(memWrEn), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_wren_after", 32'(memWrEn), 32'h0);
    chk("rstmid_ready", 32'(reqReady), 32'h1);
    chk("rstmid_respValid", 32'(respValid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 32'h0;
    chk("rstmid_memword", mem[16], 32'h5566_7788);
    chk("rstmid_respRData", respRData, 32'h0);
    model_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, er, em, el);
    run_and_check("rstmid_load", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, er, em, el);

    // Back-to-back loads with reqValid held high.
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'd2; reqSigned = 1'b0; reqAddr = 32'h10;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      rdy[i] = reqReady;
      if (i % 3 == 2) chk($sformatf("b2b_data%0d", i), respRData, 32'hDEAD_BEEF);
    end
    reqValid = 1'b0;
    for (int i = 0; i < 12; i++) chk($sformatf("b2b_ready%0d", i), 32'(rdy[i]), (i % 3 == 0) ? 32'h1 : 32'h0);
    last_rdata = 32'hDEAD_BEEF;

    // Randomized traffic against the byte-array model.
    for (int i = 0; i < 150; i++) begin
      rwr = 1'($urandom_range(0, 1));
      rsz = 2'($urandom_range(0, 3));
      rsg = 1'($urandom_range(0, 1));
      ra  = 32'($urandom_range(0, 255));
      rwd = $urandom;
      model_req(rwr, rsz, rsg, int'(ra), rwd, er, em, el);
      run_and_check($sformatf("rnd%0d", i), rwr, rsz, rsg, ra, rwd, er, em, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
